operand_stage: RTL and testbench
================================

// Module: operand_stage
// PURPOSE
//  Upstream neighbour of the 8-bit ALU. Holds the register file and the operand
//  pipeline register that drives the ALU's data1/data2/operation inputs.
//  - Selects the immediate or register operand for data2.
//  - Negates data2 for SUB. The ALU only adds, so SUB is ADD with a negated data2.
//  - Accepts ALU write-back data.
//  - Valid/ready handshake on both sides.
// PARAMETERS
//  DATA_W    8  operand / register width
//  ADDR_W    3  register address width
//  NUM_REGS  8  register count (2**ADDR_W)
//  BYPASS    1  1 = same-cycle write-back forwarded to reads; 0 = read old value
// PORTS
//  clk         in   1       single clock, all state updates on posedge
//  reset_n     in   1       synchronous, active-low reset
//  in_valid    in   1       decoded instruction present
//  in_ready    out  1       stage can accept instruction this cycle
//  rs1_addr    in   ADDR_W  source register for data1
//  rs2_addr    in   ADDR_W  source register for data2
//  imm         in   DATA_W  immediate value
//  imm_sel     in   1       1 = data2 from imm, 0 = from rs2
//  neg_sel     in   1       1 = two's-complement data2 (SUB)
//  op_in       in   3       ALU operation code, carried through
//  rd_in       in   ADDR_W  destination register, carried through
//  wen_in      in   1       instruction writes rd, carried through
//  wb_en       in   1       write-back strobe (from ALU result path)
//  wb_addr     in   ADDR_W  write-back register
//  wb_data     in   DATA_W  write-back data
//  out_valid   out  1       data1/data2/operation valid for ALU
//  out_ready   in   1       downstream consumes this cycle
//  data1       out  DATA_W  ALU operand 1 (registered)
//  data2       out  DATA_W  ALU operand 2 (registered, post imm/neg)
//  operation   out  3       ALU op (registered)
//  rd_out      out  ADDR_W  destination register (registered)
//  wen_out     out  1       write enable (registered)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    - all NUM_REGS registers are cleared to 0;
//    - out_valid=0; data1=data2=0; operation=3'b000; rd_out=0; wen_out=0.
//    - Reset mid-transfer drops the held instruction, and wb_en is ignored
//      that cycle.
//  - Register file:
//    - writes wb_data to reg[wb_addr] at posedge when wb_en=1;
//    - reads are combinational;
//    - BYPASS=1 and wb_en && wb_addr==rsX: the read returns wb_data.
//  - Operand path (combinational, before the pipeline register):
//    - b = imm_sel ? imm : reg[rs2];
//    - d2 = neg_sel ? (~b + 1) mod 2**DATA_W : b.
//    - Negation wraps, so 8'h80 stays 8'h80 and 0 stays 0.
//  - Handshake:
//    - in_ready = !out_valid || out_ready (combinational);
//    - accept = in_valid && in_ready;
//    - on accept the pipeline register loads {reg[rs1], d2, op_in, rd_in,
//      wen_in} and sets out_valid=1;
//    - on out_ready && !accept, out_valid clears.
//    - Latency is 1 clk from accept to out_valid.
//  - Back-pressure (out_valid=1 && out_ready=0): outputs stay stable and
//    in_ready=0.
//  - Simultaneous consume and accept: the new instruction replaces the old one
//    with no bubble, so full throughput is 1 instr/clk.
//  - Write-back still updates the register file while the stage is stalled.
//    Captured operands are not refreshed.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    - DATA_W, ADDR_W;
//    - ALU op constants OP_FWD=3'b000, OP_ADD=3'b001, OP_AND=3'b010,
//      OP_OR=3'b011.
//  - Sub-module reg_file: NUM_REGS x DATA_W, 2 read ports, 1 write port, sync
//    reset, BYPASS parameter.
//  - Operand mux, negation and pipeline register live in operand_stage.
// TESTING
//  1. Reset:
//     - load reg1=8'h55, then pulse reset_n=0 for 1 clk;
//     - read r1 -> 8'h00, out_valid=0, operation=000.
//  2. Register operands:
//     - write r2=8'h0A, r3=8'h05; issue rs1=2, rs2=3, imm_sel=0, neg_sel=1,
//       op=ADD;
//     - next clk data1=8'h0A, data2=8'hFB, operation=001.
//  3. Immediate and wrap:
//     - imm=8'h80, imm_sel=1, neg_sel=1 -> data2=8'h80;
//     - imm=8'h00, neg_sel=1 -> data2=8'h00.
//  4. Bypass:
//     - BYPASS=1 with wb_en=1, wb_addr=4, wb_data=8'h3C in the same cycle as
//       an accept with rs1=4 -> data1=8'h3C;
//     - BYPASS=0 -> data1 = old r4.
//  5. Back-pressure:
//     - hold out_ready=0 for 3 clk with in_valid=1;
//     - in_ready=0 and data1/data2/operation remain stable;
//     - release -> the queued instruction appears 1 clk later, none lost or
//       duplicated.
//  6. Reset mid-stall:
//     - out_valid=1, out_ready=0, then reset_n=0;
//     - next clk out_valid=0, all regs 0, and the stalled instruction never
//       reaches the ALU.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and ALU operation codes for the operand stage and ALU
package cpu_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

endpackage

// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_W register file, two combinational read ports, one write port
module reg_file #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // clear on reset (write-back ignored that cycle), otherwise take the write-back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // combinational reads, optionally forwarding a same-cycle write-back
    always_comb begin
        rd1 = (BYPASS && wb_en && wb_addr == rs1_addr) ? wb_data : regs[rs1_addr];
        rd2 = (BYPASS && wb_en && wb_addr == rs2_addr) ? wb_data : regs[rs2_addr];
    end

endmodule

// File: rtl/operand_stage.sv
// operand_stage: register file, operand select/negate and pipeline register feeding the ALU
module operand_stage #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic              neg_sel,
    input  logic [2:0]        op_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              wen_in,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [2:0]        operation,
    output logic [ADDR_W-1:0] rd_out,
    output logic              wen_out
);

    logic [DATA_W-1:0] r1, r2, b, d2;
    logic              accept;

    reg_file #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .BYPASS  (BYPASS)
    ) u_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rd1     (r1),
        .rd2     (r2)
    );

    // operand 2 select and two's-complement negate (SUB is ADD of -b), plus handshake
    always_comb begin
        b        = imm_sel ? imm : r2;
        d2       = neg_sel ? (~b + 1'b1) : b;
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end

    // pipeline register: load on accept, drop valid when consumed with nothing new
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            data1     <= '0;
            data2     <= '0;
            operation <= cpu_pkg::OP_FWD;
            rd_out    <= '0;
            wen_out   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            data1     <= r1;
            data2     <= d2;
            operation <= op_in;
            rd_out    <= rd_in;
            wen_out   <= wen_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed and random checks of operand_stage (BYPASS=1 and BYPASS=0) against a model
module tb_operand_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, in_valid, imm_sel, neg_sel, wen_in, wb_en, out_ready;
    logic [2:0] rs1_addr, rs2_addr, rd_in, wb_addr, op_in;
    logic [7:0] imm, wb_data;

    logic       in_ready [2];
    logic       out_valid [2];
    logic       wen_out [2];
    logic [7:0] data1 [2];
    logic [7:0] data2 [2];
    logic [2:0] operation [2];
    logic [2:0] rd_out [2];

    int checks = 0;
    int failures = 0;

    operand_stage #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .imm_sel(imm_sel),
        .neg_sel(neg_sel), .op_in(op_in), .rd_in(rd_in), .wen_in(wen_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid[0]),
        .out_ready(out_ready), .data1(data1[0]), .data2(data2[0]), .operation(operation[0]),
        .rd_out(rd_out[0]), .wen_out(wen_out[0])
    );

    operand_stage #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .imm_sel(imm_sel),
        .neg_sel(neg_sel), .op_in(op_in), .rd_in(rd_in), .wen_in(wen_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid[1]),
        .out_ready(out_ready), .data1(data1[1]), .data2(data2[1]), .operation(operation[1]),
        .rd_out(rd_out[1]), .wen_out(wen_out[1])
    );

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // behavioural model: index 0 mirrors the BYPASS=0 instance, index 1 the BYPASS=1 instance
    logic [7:0] m_regs [8];
    logic       m_init = 1'b0;
    logic       m_valid, m_wen;
    logic [7:0] m_d1 [2];
    logic [7:0] m_d2 [2];
    logic [2:0] m_op, m_rd;

    // model update on each rising edge from the inputs held during the cycle
    always @(posedge clk) begin : model
        logic [7:0] a, bb;
        if (!reset_n) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_valid = 1'b0;
            m_d1[0] = 0; m_d1[1] = 0; m_d2[0] = 0; m_d2[1] = 0;
            m_op = 0; m_rd = 0; m_wen = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            if (in_valid && (!m_valid || out_ready)) begin
                for (int k = 0; k < 2; k++) begin
                    a  = (k == 1 && wb_en && wb_addr == rs1_addr) ? wb_data : m_regs[rs1_addr];
                    bb = imm_sel ? imm :
                         ((k == 1 && wb_en && wb_addr == rs2_addr) ? wb_data : m_regs[rs2_addr]);
                    m_d1[k] = a;
                    m_d2[k] = neg_sel ? 8'(0 - int'(bb)) : bb;
                end
                m_op = op_in; m_rd = rd_in; m_wen = wen_in; m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en) m_regs[wb_addr] = wb_data;
        end
    end

    // compare both DUTs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_init) begin
            for (int k = 0; k < 2; k++) begin
                cmp($sformatf("out_valid[%0d]", k), 8'(out_valid[k]), 8'(m_valid));
                cmp($sformatf("in_ready[%0d]", k), 8'(in_ready[k]), 8'(!m_valid || out_ready));
                cmp($sformatf("data1[%0d]", k), data1[k], m_d1[k]);
                cmp($sformatf("data2[%0d]", k), data2[k], m_d2[k]);
                cmp($sformatf("operation[%0d]", k), 8'(operation[k]), 8'(m_op));
                cmp($sformatf("rd_out[%0d]", k), 8'(rd_out[k]), 8'(m_rd));
                cmp($sformatf("wen_out[%0d]", k), 8'(wen_out[k]), 8'(m_wen));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] r1, input logic [2:0] r2, input logic [7:0] im,
                         input logic isel, input logic nsel, input logic [2:0] op);
        in_valid = 1'b1; rs1_addr = r1; rs2_addr = r2; imm = im;
        imm_sel = isel; neg_sel = nsel; op_in = op; rd_in = r1 ^ r2; wen_in = 1'b1;
    endtask

    task automatic both(input string nm, input int sel, input logic [7:0] exp);
        for (int k = 0; k < 2; k++) begin
            case (sel)
                0: cmp($sformatf("%s out_valid[%0d]", nm, k), 8'(out_valid[k]), exp);
                1: cmp($sformatf("%s data1[%0d]", nm, k), data1[k], exp);
                2: cmp($sformatf("%s data2[%0d]", nm, k), data2[k], exp);
                3: cmp($sformatf("%s operation[%0d]", nm, k), 8'(operation[k]), exp);
                default: cmp($sformatf("%s in_ready[%0d]", nm, k), 8'(in_ready[k]), exp);
            endcase
        end
    endtask

    initial begin
        reset_n = 0; in_valid = 0; imm_sel = 0; neg_sel = 0; wen_in = 0; wb_en = 0;
        out_ready = 1; rs1_addr = 0; rs2_addr = 0; rd_in = 0; wb_addr = 0; op_in = 0;
        imm = 0; wb_data = 0;
        tick(); tick();
        // reset clears registers, write-back during reset is ignored
        reset_n = 1; wb_en = 1; wb_addr = 1; wb_data = 8'h55;
        tick();
        reset_n = 0; wb_data = 8'h77;
        tick();
        both("reset", 0, 8'h00);
        both("reset", 3, 8'h00);
        reset_n = 1; wb_en = 0;
        issue(1, 0, 8'h00, 1, 0, OP_FWD);
        tick();
        both("reset r1", 1, 8'h00);
        both("reset r1", 0, 8'h01);
        // register operands with SUB
        in_valid = 0; wb_en = 1; wb_addr = 2; wb_data = 8'h0A;
        tick();
        wb_addr = 3; wb_data = 8'h05;
        tick();
        wb_en = 0;
        issue(2, 3, 8'h00, 0, 1, OP_ADD);
        tick();
        both("regop", 1, 8'h0A);
        both("regop", 2, 8'hFB);
        both("regop", 3, 8'h01);
        // immediate negate wraps
        issue(0, 0, 8'h80, 1, 1, OP_ADD);
        tick();
        both("neg80", 2, 8'h80);
        issue(0, 0, 8'h00, 1, 1, OP_ADD);
        tick();
        both("neg00", 2, 8'h00);
        // same-cycle write-back forwarding
        in_valid = 0; wb_en = 1; wb_addr = 4; wb_data = 8'h11;
        tick();
        wb_data = 8'h3C;
        issue(4, 0, 8'h00, 1, 0, OP_OR);
        tick();
        cmp("bypass data1[1]", data1[1], 8'h3C);
        cmp("nobypass data1[0]", data1[0], 8'h11);
        wb_en = 0;
        // back-pressure holds outputs and blocks input
        out_ready = 0;
        issue(0, 0, 8'h21, 1, 0, OP_AND);
        #1;
        both("stall", 4, 8'h00);
        repeat (3) begin
            tick();
            both("stall", 4, 8'h00);
            both("stall", 2, 8'h00);
            both("stall", 3, 8'(OP_OR));
            cmp("stall data1[1]", data1[1], 8'h3C);
        end
        out_ready = 1;
        #1;
        both("release", 4, 8'h01);
        tick();
        both("release", 0, 8'h01);
        both("release", 2, 8'h21);
        both("release", 3, 8'(OP_AND));
        in_valid = 0;
        tick();
        both("drain", 0, 8'h00);
        // reset while stalled drops the held instruction
        issue(0, 0, 8'h42, 1, 0, OP_ADD);
        tick();
        both("pre-stall", 2, 8'h42);
        out_ready = 0; in_valid = 0;
        tick();
        both("stalled", 0, 8'h01);
        reset_n = 0;
        tick();
        both("rst-stall", 0, 8'h00);
        both("rst-stall", 2, 8'h00);
        both("rst-stall", 3, 8'h00);
        reset_n = 1; out_ready = 1;
        tick();
        both("rst-stall after", 0, 8'h00);
        issue(2, 3, 8'h00, 0, 0, OP_FWD);
        tick();
        both("rst-stall r2", 1, 8'h00);
        both("rst-stall r3", 2, 8'h00);
        in_valid = 0;
        // random traffic against the model
        repeat (3000) begin
            tick();
            reset_n   = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rs1_addr  = 3'($urandom); rs2_addr = 3'($urandom); rd_in = 3'($urandom);
            imm       = 8'($urandom); imm_sel = 1'($urandom); neg_sel = 1'($urandom);
            op_in     = 3'($urandom); wen_in = 1'($urandom);
            wb_en     = ($urandom_range(0, 9) < 5);
            wb_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 3'($urandom);
            wb_data   = 8'($urandom);
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
